// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by both the host transmitter and the device receive path.
package ps2_pkg;

   localparam int unsigned PS2_TX_FRAME_EDGES = 11;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_INHIBIT,
      TX_REQ,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP,
      TX_WAIT
   } ps2_tx_state_t;

   function automatic int unsigned us2cyc(input int unsigned freq, input int unsigned us);
      return (freq / 1_000_000) * us;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for the PS/2 clock and data pads plus a falling-edge pulse on the clock.
module ps2_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_ps2_clk,
   input  logic i_ps2_data,
   output logic o_clk_s,
   output logic o_data_s,
   output logic o_clk_fall
);

   logic [1:0] r_clk_sync;
   logic [1:0] r_data_sync;
   logic       r_clk_prev;

   // Idle bus level is high; resetting to 1 avoids a spurious fall after reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
         r_data_sync <= {r_data_sync[0], i_ps2_data};
         r_clk_prev  <= r_clk_sync[1];
      end
   end

   assign o_clk_s    = r_clk_sync[1];
   assign o_data_s   = r_data_sync[1];
   assign o_clk_fall = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one byte on device clocks, check ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 25_000_000,
   parameter int unsigned INHIBIT_US = 120,
   parameter int unsigned TIMEOUT_US = 20000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_tx_valid,
   input  logic [7:0] i_tx_data,
   output logic       o_tx_ready,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic       o_ps2_clk_oe,
   output logic       o_ps2_data_oe,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_ack_err,
   output logic       o_timeout
);

   localparam int unsigned INHIBIT_CYC = us2cyc(CLK_FREQ, INHIBIT_US);
   localparam int unsigned TIMEOUT_CYC = us2cyc(CLK_FREQ, TIMEOUT_US);
   localparam int unsigned TO_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [15:0]     INH_LAST = 16'(INHIBIT_CYC - 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

   ps2_tx_state_t   r_state;
   ps2_tx_state_t   w_next;
   logic [15:0]     r_inh_cnt;
   logic [TO_W-1:0] r_to_cnt;
   logic [7:0]      r_shreg;
   logic [2:0]      r_bitcnt;
   logic            r_parity;
   logic            r_done;
   logic            r_ack_err;
   logic            r_timeout;

   logic w_clk_s;
   logic w_data_s;
   logic w_fall;
   logic w_active;
   logic w_done_set;
   logic w_err_set;
   logic w_to_set;

   ps2_sync_edge u_sync (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_ps2_clk  (i_ps2_clk),
      .i_ps2_data (i_ps2_data),
      .o_clk_s    (w_clk_s),
      .o_data_s   (w_data_s),
      .o_clk_fall (w_fall)
   );

   assign w_active = (r_state == TX_START) || (r_state == TX_DATA) ||
                     (r_state == TX_PARITY) || (r_state == TX_STOP);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= TX_IDLE;
         r_done    <= 1'b0;
         r_ack_err <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_done    <= w_done_set;
         r_ack_err <= w_err_set;
         r_timeout <= w_to_set;
      end
   end

   // Timeout is checked before the edge so it wins when both land in one cycle.
   always_comb begin
      w_next     = r_state;
      w_done_set = 1'b0;
      w_err_set  = 1'b0;
      w_to_set   = 1'b0;
      case (r_state)
         TX_IDLE:    if (i_tx_valid) w_next = TX_INHIBIT;
         TX_INHIBIT: if (r_inh_cnt == INH_LAST) w_next = TX_REQ;
         TX_REQ:     w_next = TX_START;
         TX_START, TX_DATA, TX_PARITY, TX_STOP: begin
            if (r_to_cnt == TO_LAST) begin
               w_next   = TX_IDLE;
               w_to_set = 1'b1;
            end else if (w_fall) begin
               case (r_state)
                  TX_START:  w_next = TX_DATA;
                  TX_DATA:   if (r_bitcnt == 3'd7) w_next = TX_PARITY;
                  TX_PARITY: w_next = TX_STOP;
                  default: begin
                     if (w_data_s) begin
                        w_next    = TX_IDLE;
                        w_err_set = 1'b1;
                     end else begin
                        w_next = TX_WAIT;
                     end
                  end
               endcase
            end
         end
         TX_WAIT: begin
            if (w_clk_s && w_data_s) begin
               w_next     = TX_IDLE;
               w_done_set = 1'b1;
            end
         end
         default: w_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_inh_cnt <= '0;
         r_to_cnt  <= '0;
         r_shreg   <= '0;
         r_bitcnt  <= '0;
         r_parity  <= 1'b0;
      end else begin
         if (r_state == TX_IDLE && i_tx_valid) begin
            r_shreg  <= i_tx_data;
            r_parity <= ~^i_tx_data;
            r_bitcnt <= '0;
         end else if (r_state == TX_DATA && w_fall && r_bitcnt != 3'd7) begin
            r_shreg  <= {1'b0, r_shreg[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
         end
         r_inh_cnt <= (r_state == TX_INHIBIT) ? r_inh_cnt + 16'd1 : 16'd0;
         if (!w_active)
            r_to_cnt <= '0;
         else if (r_to_cnt != TO_LAST)
            r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   always_comb begin
      o_ps2_clk_oe  = (r_state == TX_INHIBIT) || (r_state == TX_REQ);
      o_ps2_data_oe = 1'b0;
      case (r_state)
         TX_REQ, TX_START: o_ps2_data_oe = 1'b1;
         TX_DATA:          o_ps2_data_oe = ~r_shreg[0];
         TX_PARITY:        o_ps2_data_oe = ~r_parity;
         default:          o_ps2_data_oe = 1'b0;
      endcase
   end

   assign o_tx_ready = (r_state == TX_IDLE);
   assign o_busy     = (r_state != TX_IDLE);
   assign o_done     = r_done;
   assign o_ack_err  = r_ack_err;
   assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a device BFM, vector table, random frames, corner sequences.
module tb_ps2_host_tx;

   localparam int unsigned CLK_FREQ   = 10_000_000;
   localparam int unsigned INHIBIT_US = 120;
   localparam int unsigned TIMEOUT_US = 2000;
   localparam int INH_CYC = CLK_FREQ / 1_000_000 * INHIBIT_US;
   localparam int TO_CYC  = CLK_FREQ / 1_000_000 * TIMEOUT_US;
   localparam int HALF    = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, clk_oe, data_oe, busy, done, ack_err, timeout;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       line_clk, line_data;

   assign line_clk  = ~(clk_oe | dev_clk_low);
   assign line_data = ~(data_oe | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .CLK_FREQ   (CLK_FREQ),
      .INHIBIT_US (INHIBIT_US),
      .TIMEOUT_US (TIMEOUT_US)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_tx_valid    (tx_valid),
      .i_tx_data     (tx_data),
      .o_tx_ready    (tx_ready),
      .i_ps2_clk     (line_clk),
      .i_ps2_data    (line_data),
      .o_ps2_clk_oe  (clk_oe),
      .o_ps2_data_oe (data_oe),
      .o_busy        (busy),
      .o_done        (done),
      .o_ack_err     (ack_err),
      .o_timeout     (timeout)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_done   = 0;
   int n_err    = 0;
   int n_to     = 0;
   int n_rdy    = 0;
   int t_start  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done === 1'b1)     n_done <= n_done + 1;
      if (ack_err === 1'b1)  n_err  <= n_err + 1;
      if (timeout === 1'b1)  n_to   <= n_to + 1;
      if (tx_ready === 1'b1) n_rdy  <= n_rdy + 1;
   end

   typedef struct {
      logic [7:0] data;
      bit         ack;
      logic [9:0] exp_bits;
      bit         exp_done;
      bit         exp_err;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Frame as the device sees it: data LSB first, odd parity, stop bit.
   function automatic logic [9:0] model_frame(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
   endfunction

   task automatic device_rx(input bit ack, input int nfalls, output logic [9:0] rx, output bit ok);
      int w = 0;
      rx = '0;
      ok = 1'b0;
      while (!(line_clk && !line_data) && w < INH_CYC + 200) begin
         tick();
         w++;
      end
      if (w >= INH_CYC + 200) return;
      repeat (HALF) tick();
      for (int k = 1; k <= nfalls; k++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) tick();
         dev_clk_low = 1'b0;
         if (k <= 10) rx[k-1] = line_data;
         if (k == 10 && ack && nfalls == 11) dev_data_low = 1'b1;
         repeat (HALF) tick();
      end
      dev_data_low = 1'b0;
      ok = 1'b1;
   endtask

   task automatic send_start(input logic [7:0] d, input string tag);
      int w = 0;
      int inh = 0;
      while (!tx_ready && w < 200) begin
         tick();
         w++;
      end
      chk({tag, "_ready"}, 32'(tx_ready), 1);
      tx_valid = 1'b1;
      tx_data  = d;
      tick();
      tx_valid = 1'b0;
      chk({tag, "_accept"}, 32'(tx_ready), 0);
      while (clk_oe && !data_oe && inh < INH_CYC + 10) begin
         inh++;
         tick();
      end
      chk({tag, "_inhibit_cyc"}, inh, INH_CYC);
      chk({tag, "_req"}, {clk_oe, data_oe}, 2'b11);
      tick();
      chk({tag, "_start"}, {clk_oe, data_oe}, 2'b01);
      t_start = cyc;
   endtask

   task automatic run_frame(input logic [7:0] d, input bit ack, input logic [9:0] exp_bits,
                            input bit exp_done, input bit exp_err, input string tag);
      int d0, e0, o0;
      int w = 0;
      logic [9:0] rx;
      bit ok;
      send_start(d, tag);
      d0 = n_done;
      e0 = n_err;
      o0 = n_to;
      device_rx(ack, 11, rx, ok);
      chk({tag, "_bfm"}, 32'(ok), 1);
      chk({tag, "_bits"}, rx, exp_bits);
      while (busy && w < 100) begin
         tick();
         w++;
      end
      tick();
      tick();
      chk({tag, "_done"}, n_done - d0, exp_done);
      chk({tag, "_ack_err"}, n_err - e0, exp_err);
      chk({tag, "_no_timeout"}, n_to - o0, 0);
      chk({tag, "_oe_idle"}, {clk_oe, data_oe}, 2'b00);
      chk({tag, "_ready_after"}, 32'(tx_ready), 1);
   endtask

   initial begin
      int d0, e0, o0, r0, w;
      logic [9:0] rx;
      bit ok;
      logic [7:0] rd;
      bit rack;

      vecs[0] = '{data: 8'hED, ack: 1'b1, exp_bits: {2'b11, 8'hED}, exp_done: 1'b1, exp_err: 1'b0};
      vecs[1] = '{data: 8'h00, ack: 1'b1, exp_bits: {2'b11, 8'h00}, exp_done: 1'b1, exp_err: 1'b0};
      vecs[2] = '{data: 8'h01, ack: 1'b1, exp_bits: {2'b10, 8'h01}, exp_done: 1'b1, exp_err: 1'b0};
      vecs[3] = '{data: 8'hA5, ack: 1'b0, exp_bits: {2'b11, 8'hA5}, exp_done: 1'b0, exp_err: 1'b1};

      // reset state
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_oe", {clk_oe, data_oe}, 2'b00);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pulses", {done, ack_err, timeout}, 3'b000);
      chk("rst_ready", 32'(tx_ready), 1);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 32'(tx_ready), 1);

      foreach (vecs[i])
         run_frame(vecs[i].data, vecs[i].ack, vecs[i].exp_bits, vecs[i].exp_done, vecs[i].exp_err,
                   $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         rd   = 8'($urandom);
         rack = 1'($urandom_range(0, 1));
         run_frame(rd, rack, model_frame(rd), rack, !rack, $sformatf("rand%0d_%02h", i, rd));
      end

      // device stops clocking after 3 falls
      send_start(8'h5A, "to");
      d0 = n_done;
      e0 = n_err;
      device_rx(1'b1, 3, rx, ok);
      w = 0;
      while (!timeout && w < TO_CYC + 100) begin
         tick();
         w++;
      end
      chk("to_seen", 32'(timeout), 1);
      chk("to_latency", cyc - t_start, TO_CYC);
      chk("to_oe", {clk_oe, data_oe}, 2'b00);
      chk("to_busy", 32'(busy), 0);
      tick();
      chk("to_width", 32'(timeout), 0);
      chk("to_other_pulses", (n_done - d0) + (n_err - e0), 0);

      // tx_valid held high across two bytes
      w = 0;
      while (!tx_ready && w < 200) begin
         tick();
         w++;
      end
      d0 = n_done;
      tx_valid = 1'b1;
      tx_data  = 8'hF4;
      tick();
      chk("held_accept1", 32'(tx_ready), 0);
      r0 = n_rdy;
      tx_data = 8'hFF;
      device_rx(1'b1, 11, rx, ok);
      chk("held_bits1", rx, model_frame(8'hF4));
      w = 0;
      while (!done && w < 100) begin
         tick();
         w++;
      end
      chk("held_done1", 32'(done), 1);
      chk("held_ready_during1", n_rdy - r0, 1);
      tick();
      chk("held_accept2", 32'(tx_ready), 0);
      tx_valid = 1'b0;
      device_rx(1'b1, 11, rx, ok);
      chk("held_bits2", rx, model_frame(8'hFF));
      w = 0;
      while (busy && w < 100) begin
         tick();
         w++;
      end
      tick();
      chk("held_done_total", n_done - d0, 2);

      // reset while bit 4 (a 0 in 0xED) is on the bus
      send_start(8'hED, "rstmid");
      device_rx(1'b1, 5, rx, ok);
      chk("rstmid_bit4_driven", {clk_oe, data_oe}, 2'b01);
      d0 = n_done;
      e0 = n_err;
      o0 = n_to;
      rst_n = 1'b0;
      tick();
      chk("rstmid_oe", {clk_oe, data_oe}, 2'b00);
      chk("rstmid_busy", 32'(busy), 0);
      rst_n = 1'b1;
      repeat (20) tick();
      chk("rstmid_no_pulse", (n_done - d0) + (n_err - e0) + (n_to - o0), 0);
      run_frame(8'hFF, 1'b1, {2'b11, 8'hFF}, 1'b1, 1'b0, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, %0d cycles elapsed", cyc);
      $fatal(1);
   end

endmodule
